game_control: RTL and testbench

//  Game-state controller downstream of the obstacle generator. Tracks player lane from move

---
 rtl/game_control.sv | 117 +++++++++++
 tb/tb_game_control.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_control.sv
// Game-state controller: player lane, collisions against the nearest obstacle row,
// lives with post-hit grace, prescaled score, and obstacle-generator hold outside play.
module game_control #(
    parameter int unsigned SCORE_CYCLES = 100_000_000,
    parameter int unsigned GRACE_CYCLES = 50_000_000,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned SCORE_MAX    = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_start,
    input  logic [2:0]  obstacle4,
    output logic [2:0]  player,
    output logic        obstacles_rst,
    output logic [1:0]  lives,
    output logic [13:0] score,
    output logic        hit_flash,
    output logic        game_over
);

    localparam int unsigned PW = $clog2(SCORE_CYCLES + 1);
    localparam int unsigned GW = $clog2(GRACE_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCORE_CYCLES - 1);
    localparam logic [GW-1:0] GRACE_LAST = GW'(GRACE_CYCLES - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);
    localparam logic [13:0]   SCORE_TOP  = 14'(SCORE_MAX);

    typedef enum logic [1:0] {IDLE, RUN, GRACE, OVER} state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [GW-1:0] grace;

    logic [2:0]  moved;
    logic        collide;
    logic        pre_wrap;
    logic [13:0] score_next;

    always_comb begin
        moved = player;
        if (btn_left && !btn_right && player != 3'b100)
            moved = player << 1;
        else if (btn_right && !btn_left && player != 3'b001)
            moved = player >> 1;
        collide    = |(player & obstacle4);
        pre_wrap   = (prescaler == PRE_LAST);
        score_next = (pre_wrap && score < SCORE_TOP) ? score + 14'd1 : score;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            player        <= 3'b010;
            obstacles_rst <= 1'b1;
            lives         <= LIVES_INIT;
            score         <= '0;
            hit_flash     <= 1'b0;
            game_over     <= 1'b0;
            prescaler     <= '0;
            grace         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_start) begin
                        state         <= RUN;
                        obstacles_rst <= 1'b0;
                    end
                end
                RUN: begin
                    player    <= moved;
                    prescaler <= pre_wrap ? '0 : prescaler + 1'b1;
                    score     <= score_next;
                    if (collide) begin
                        if (lives > 2'd1) begin
                            lives     <= lives - 2'd1;
                            state     <= GRACE;
                            hit_flash <= 1'b1;
                            grace     <= '0;
                        end else begin
                            lives         <= 2'd0;
                            state         <= OVER;
                            game_over     <= 1'b1;
                            obstacles_rst <= 1'b1;
                        end
                    end
                end
                GRACE: begin
                    player    <= moved;
                    prescaler <= pre_wrap ? '0 : prescaler + 1'b1;
                    score     <= score_next;
                    if (grace == GRACE_LAST) begin
                        state     <= RUN;
                        hit_flash <= 1'b0;
                        grace     <= '0;
                    end else begin
                        grace <= grace + 1'b1;
                    end
                end
                OVER: begin
                    // Acknowledge returns to IDLE with a fresh game already loaded.
                    if (btn_start) begin
                        state     <= IDLE;
                        game_over <= 1'b0;
                        player    <= 3'b010;
                        lives     <= LIVES_INIT;
                        score     <= '0;
                        prescaler <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: randomized and directed play checked against a lane/lives/score model.
module tb_game_control;

    localparam int SC = 10;
    localparam int GC = 20;
    localparam int NL = 3;
    localparam int SMAX = 9999;
    localparam int M_IDLE = 0, M_RUN = 1, M_GRACE = 2, M_OVER = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_left, btn_right, btn_start;
    logic [2:0]  obstacle4;
    logic [2:0]  player;
    logic        obstacles_rst;
    logic [1:0]  lives;
    logic [13:0] score;
    logic        hit_flash, game_over;

    logic        s2_start;
    logic [2:0]  player2;
    logic        obstacles_rst2;
    logic [1:0]  lives2;
    logic [13:0] score2;
    logic        hit_flash2, game_over2;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode, m_lane, m_lives, m_score, m_ticks, m_gcnt;

    always #5 clk = ~clk;

    game_control #(.SCORE_CYCLES(SC), .GRACE_CYCLES(GC), .LIVES(NL)) dut (
        .clk(clk), .rst(rst), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start), .obstacle4(obstacle4), .player(player),
        .obstacles_rst(obstacles_rst), .lives(lives), .score(score),
        .hit_flash(hit_flash), .game_over(game_over)
    );

    // Small saturation value so the ceiling is reachable in a short run.
    game_control #(.SCORE_CYCLES(SC), .GRACE_CYCLES(GC), .LIVES(NL), .SCORE_MAX(4)) dut_sat (
        .clk(clk), .rst(rst), .btn_left(1'b0), .btn_right(1'b0),
        .btn_start(s2_start), .obstacle4(3'b000), .player(player2),
        .obstacles_rst(obstacles_rst2), .lives(lives2), .score(score2),
        .hit_flash(hit_flash2), .game_over(game_over2)
    );

    wire [21:0] act_vec = {player, obstacles_rst, lives, score, hit_flash, game_over};

    function automatic logic [21:0] exp_vec();
        logic [2:0] p;
        p = 3'(1 << m_lane);
        return {p, (m_mode == M_IDLE || m_mode == M_OVER), 2'(m_lives), 14'(m_score),
                (m_mode == M_GRACE), (m_mode == M_OVER)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_lane = 1; m_lives = NL; m_score = 0; m_ticks = 0; m_gcnt = 0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit s, input logic [2:0] obs);
        int  prev;
        bit  hit;
        prev = m_mode;
        hit  = obs[m_lane];
        case (prev)
            M_IDLE: if (s) m_mode = M_RUN;
            M_RUN, M_GRACE: begin
                if (l && !r && m_lane < 2) m_lane++;
                else if (r && !l && m_lane > 0) m_lane--;
                m_ticks++;
                if (m_ticks == SC) begin
                    m_ticks = 0;
                    if (m_score < SMAX) m_score++;
                end
                if (prev == M_GRACE) begin
                    m_gcnt++;
                    if (m_gcnt == GC) m_mode = M_RUN;
                end else if (hit) begin
                    if (m_lives > 1) begin
                        m_lives--; m_mode = M_GRACE; m_gcnt = 0;
                    end else begin
                        m_lives = 0; m_mode = M_OVER;
                    end
                end
            end
            default: if (s) begin
                m_mode = M_IDLE; m_lane = 1; m_lives = NL; m_score = 0; m_ticks = 0;
            end
        endcase
    endtask

    task automatic cycle(input bit l, input bit r, input bit s, input logic [2:0] obs);
        @(negedge clk);
        btn_left = l; btn_right = r; btn_start = s; obstacle4 = obs;
        @(posedge clk);
        model_step(l, r, s, obs);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        btn_left = 0; btn_right = 0; btn_start = 0; obstacle4 = 0; s2_start = 0;
        @(negedge clk);
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn_left = 0; btn_right = 0; btn_start = 0; obstacle4 = 0; s2_start = 0;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (act_vec !== 22'b010_1_11_00000000000000_0_0) begin
            n_fail++; $display("FAIL reset_values: got %h expected %h", act_vec, 22'b010_1_11_00000000000000_0_0);
        end
        n_checks++;
        if (act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_model: got %h expected %h", act_vec, exp_vec());
        end
        rst = 1'b1;
    endtask

    task automatic test_start_score();
        cycle(0, 0, 1, 3'b000);
        n_checks++;
        if (act_vec !== 22'b010_0_11_00000000000000_0_0) begin
            n_fail++; $display("FAIL start_run: got %h expected %h", act_vec, 22'b010_0_11_00000000000000_0_0);
        end
        for (int i = 0; i < 30; i++) begin
            cycle(0, 0, 0, 3'b000);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL score_run cyc %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        n_checks++;
        if (score !== 14'd3) begin
            n_fail++; $display("FAIL score_after_30: got %0d expected 3", score);
        end
    endtask

    task automatic test_moves();
        logic [2:0] exp_p;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 3'b000);
            cycle(0, 0, 0, 3'b000);
            n_checks++;
            if (player !== 3'b100 || act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL move_left %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
        cycle(0, 1, 0, 3'b000);
        exp_p = player;
        cycle(1, 1, 0, 3'b000);
        n_checks++;
        if (player !== 3'b010 || player !== exp_p) begin
            n_fail++; $display("FAIL move_both: got %b expected 010", player);
        end
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 3'b000);
        n_checks++;
        if (player !== 3'b001 || act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL move_right_edge: got %h expected %h", act_vec, exp_vec());
        end
        cycle(1, 0, 0, 3'b000);
    endtask

    task automatic test_hit_grace();
        for (int i = 0; i < GC; i++) begin
            cycle(0, 0, 0, 3'b010);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL grace_hold cyc %0d: got %h expected %h", i, act_vec, exp_vec());
            end
            if (i == 0) begin
                n_checks++;
                if (lives !== 2'd2 || hit_flash !== 1'b1) begin
                    n_fail++; $display("FAIL first_hit: lives %0d flash %b expected 2 1", lives, hit_flash);
                end
            end
        end
        cycle(0, 0, 0, 3'b000);
        n_checks++;
        if (hit_flash !== 1'b0 || lives !== 2'd2 || act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL grace_exit: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    task automatic test_game_over();
        int frozen;
        do_reset();
        cycle(0, 0, 1, 3'b000);
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 0, 3'(1 << m_lane));
            cycle(0, 0, 0, 3'b000);
            n_checks++;
            if (lives !== 2'(3 - k) || act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL hit_%0d: got %h expected %h", k, act_vec, exp_vec());
            end
            for (int i = 0; i < GC; i++) cycle(0, 0, 0, 3'b000);
        end
        n_checks++;
        if (game_over !== 1'b1 || obstacles_rst !== 1'b1 || act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL over_flags: got %h expected %h", act_vec, exp_vec());
        end
        frozen = m_score;
        for (int i = 0; i < 15; i++) cycle(1, 0, 0, 3'b111);
        n_checks++;
        if (score !== 14'(frozen) || act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL over_frozen: got %h expected %h", act_vec, exp_vec());
        end
        cycle(0, 0, 1, 3'b000);
        n_checks++;
        if (act_vec !== 22'b010_1_11_00000000000000_0_0) begin
            n_fail++; $display("FAIL over_ack: got %h expected %h", act_vec, 22'b010_1_11_00000000000000_0_0);
        end
    endtask

    task automatic test_random();
        bit l, r, s;
        logic [2:0] obs;
        for (int i = 0; i < 600; i++) begin
            l = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 5) == 0);
            s = ($urandom_range(0, 15) == 0);
            obs = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            cycle(l, r, s, obs);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk); s2_start = 1'b1;
        @(negedge clk); s2_start = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            @(posedge clk); #1;
            if (n == 30 || n == 50 || n == 70) begin
                n_checks++;
                if (score2 !== 14'((n / SC) < 4 ? (n / SC) : 4) || game_over2 !== 1'b0) begin
                    n_fail++; $display("FAIL saturate n=%0d: got %0d expected %0d", n, score2, ((n / SC) < 4 ? (n / SC) : 4));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(0, 0, 1, 3'b000);
        for (int i = 0; i < 12; i++) cycle(1, 0, 0, 3'b000);
        cycle(0, 0, 0, 3'b100);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 3'b000);
        n_checks++;
        if (hit_flash !== 1'b1 || act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL pre_async_grace: got %h expected %h", act_vec, exp_vec());
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (act_vec !== 22'b010_1_11_00000000000000_0_0) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", act_vec, 22'b010_1_11_00000000000000_0_0);
        end
        @(negedge clk);
        model_reset();
        rst = 1'b1;
        cycle(0, 0, 1, 3'b000);
        n_checks++;
        if (act_vec !== exp_vec()) begin
            n_fail++; $display("FAIL after_async: got %h expected %h", act_vec, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_start_score();
        test_moves();
        test_hit_grace();
        test_game_over();
        test_random();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
